// File: rtl/ship_placement_ctrl.sv
// Ship placement controller: steps a player through direction, orientation and X/Y for each
// vessel, asks an external validator for overlap, and strobes accepted pieces into board memory.
module ship_placement_ctrl #(
  parameter int unsigned          BOARD_N     = 8,
  parameter int unsigned          N_TYPES     = 5,
  parameter logic [3*N_TYPES-1:0] QTY         = {3'd1, 3'd1, 3'd2, 3'd2, 3'd5},
  parameter int unsigned          N_ORIENT    = 5,
  parameter int unsigned          VAL_TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        enter,
  input  logic                        select,
  input  logic                        mode,
  output logic                        val_req,
  input  logic                        val_done,
  input  logic                        val_conflict,
  output logic                        wr_en,
  output logic                        jogador,
  output logic [$clog2(N_TYPES)-1:0]  tipo,
  output logic [$clog2(BOARD_N)-1:0]  x,
  output logic [$clog2(BOARD_N)-1:0]  y,
  output logic                        direcao,
  output logic [$clog2(N_ORIENT)-1:0] orientacao,
  output logic                        ready,
  output logic [3:0]                  state
);

  localparam int unsigned TW = $clog2(N_TYPES);
  localparam int unsigned XW = $clog2(BOARD_N);
  localparam int unsigned OW = $clog2(N_ORIENT);
  localparam int unsigned CW = $clog2(VAL_TIMEOUT + 1);

  localparam logic [XW-1:0] XLast    = XW'(BOARD_N - 1);
  localparam logic [OW-1:0] OLast    = OW'(N_ORIENT - 1);
  localparam logic [TW-1:0] TypeLast = TW'(N_TYPES - 1);
  localparam logic [CW-1:0] TimeLast = CW'(VAL_TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StDir      = 4'd1,
    StOrient   = 4'd2,
    StDefX     = 4'd3,
    StDefY     = 4'd4,
    StValidate = 4'd5,
    StStore    = 4'd6,
    StNext     = 4'd7,
    StDone     = 4'd8
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tipo_q, tipo_d;
  logic [2:0]    count_q, count_d;
  logic [XW-1:0] x_q, x_d, y_q, y_d;
  logic          dir_q, dir_d;
  logic [OW-1:0] orient_q, orient_d;
  logic          jog_q, jog_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] timer_q, timer_d;
  logic          enter_prev_q, select_prev_q;

  logic       enter_edge, select_edge;
  logic [2:0] qty_cur;
  logic [3:0] count_inc;

  // Enter wins a tie, so a simultaneous select is dropped.
  assign enter_edge  = enter & ~enter_prev_q;
  assign select_edge = select & ~select_prev_q & ~enter_edge;
  assign count_inc   = {1'b0, count_q} + 4'd1;

  always_comb begin
    qty_cur = '0;
    for (int i = 0; i < int'(N_TYPES); i++) begin
      if (tipo_q == TW'(i)) qty_cur = QTY[3*i +: 3];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      tipo_q        <= '0;
      count_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      dir_q         <= 1'b0;
      orient_q      <= '0;
      jog_q         <= 1'b0;
      mode_q        <= 1'b0;
      timer_q       <= '0;
      enter_prev_q  <= 1'b0;
      select_prev_q <= 1'b0;
    end else if (enable) begin
      state_q       <= state_d;
      tipo_q        <= tipo_d;
      count_q       <= count_d;
      x_q           <= x_d;
      y_q           <= y_d;
      dir_q         <= dir_d;
      orient_q      <= orient_d;
      jog_q         <= jog_d;
      mode_q        <= mode_d;
      timer_q       <= timer_d;
      enter_prev_q  <= enter;
      select_prev_q <= select;
    end
  end

  always_comb begin
    state_d  = state_q;
    tipo_d   = tipo_q;
    count_d  = count_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    orient_d = orient_q;
    jog_d    = jog_q;
    mode_d   = mode_q;
    timer_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (enter_edge) begin
          state_d  = StDir;
          mode_d   = mode;
          tipo_d   = '0;
          count_d  = '0;
          jog_d    = 1'b0;
          x_d      = '0;
          y_d      = '0;
          dir_d    = 1'b0;
          orient_d = '0;
        end
      end
      StDir: begin
        if (enter_edge)       state_d = StOrient;
        else if (select_edge) dir_d   = ~dir_q;
      end
      StOrient: begin
        if (enter_edge)       state_d  = StDefX;
        else if (select_edge) orient_d = (orient_q == OLast) ? '0 : orient_q + OW'(1);
      end
      StDefX: begin
        if (enter_edge)       state_d = StDefY;
        else if (select_edge) x_d     = (x_q == XLast) ? '0 : x_q + XW'(1);
      end
      StDefY: begin
        if (enter_edge)       state_d = StValidate;
        else if (select_edge) y_d     = (y_q == XLast) ? '0 : y_q + XW'(1);
      end
      StValidate: begin
        // A silent validator is treated like a reported conflict.
        if (val_done)                state_d = val_conflict ? StDefX : StStore;
        else if (timer_q == TimeLast) state_d = StDefX;
        else                          timer_d = timer_q + CW'(1);
      end
      StStore: state_d = StNext;
      StNext: begin
        state_d = StDir;
        if (count_inc < {1'b0, qty_cur}) begin
          count_d = count_inc[2:0];
        end else begin
          count_d = '0;
          if (tipo_q != TypeLast) begin
            tipo_d = tipo_q + TW'(1);
          end else if (mode_q && !jog_q) begin
            jog_d  = 1'b1;
            tipo_d = '0;
          end else begin
            state_d = StDone;
          end
        end
        if (state_d == StDir) begin
          x_d      = '0;
          y_d      = '0;
          dir_d    = 1'b0;
          orient_d = '0;
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    val_req = (state_q == StValidate);
    wr_en   = (state_q == StStore);
    ready   = (state_q == StDone);
  end

  assign state      = state_q;
  assign tipo       = tipo_q;
  assign x          = x_q;
  assign y          = y_q;
  assign direcao    = dir_q;
  assign orientacao = orient_q;
  assign jogador    = jog_q;

endmodule
